// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg
//   Shared definitions for the PWM duty controller slice:
//     DUTY_W        - width of the duty / target value
//     pwm_state_e   - ramp FSM states (IDLE, RAMP_UP, RAMP_DN)
//     KEY_INC/DEC   - operator key encodings
//     state_from()  - ramp direction from a duty/target pair
package pwm_ctrl_pkg;

    localparam int unsigned DUTY_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } pwm_state_e;

    localparam logic [1:0] KEY_INC = 2'b01;
    localparam logic [1:0] KEY_DEC = 2'b10;

    function automatic pwm_state_e state_from(input logic [DUTY_W-1:0] duty,
                                              input logic [DUTY_W-1:0] target);
        pwm_state_e st;
        if (duty < target) begin
            st = RAMP_UP;
        end else if (duty > target) begin
            st = RAMP_DN;
        end else begin
            st = IDLE;
        end
        return st;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen
//   Free-running TICK_W-bit counter; emits a one-cycle tick in the cycle
//   after the counter wraps from all-ones to zero.
//   Ports:
//     clk  in   system clock
//     rst  in   synchronous active-high reset (counter and tick cleared)
//     tick out  one-cycle pulse every 2^TICK_W cycles
module pwm_tick_gen
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned TICK_W = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic              tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = (cnt_q == '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl
//   Ramped PWM duty controller. A target duty is set either by a host
//   command (priority) or by operator keys on each ramp tick; the output
//   duty walks towards the target by STEP per tick without overshoot.
//   Ports:
//     clk        in   system clock, all logic on posedge
//     rst        in   synchronous active-high reset
//     key[1:0]   in   01 increase, 10 decrease, 00/11 no action
//     set_valid  in   host command valid
//     set_duty   in   host target duty (clamped to DUTY_MAX)
//     set_ready  out  host command acceptable (= !busy)
//     duty       out  registered duty to the PWM generator
//     duty_upd   out  one-cycle pulse in the cycle after duty changes
//     busy       out  ramp in progress
//   Build option: define KEY_DEBOUNCE_EN to synchronise key and act only
//   when the key is stable across two consecutive ticks.
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned        TICK_W    = 16,
    parameter int unsigned        STEP      = 1,
    parameter logic [DUTY_W-1:0]  DUTY_INIT = 10'd0,
    parameter logic [DUTY_W-1:0]  DUTY_MAX  = 10'd1016
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        key,
    input  logic              set_valid,
    input  logic [DUTY_W-1:0] set_duty,
    output logic              set_ready,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic              busy
);

    // One extra bit so +STEP / -STEP overflow and underflow are visible.
    localparam logic [DUTY_W:0] STEP_X = STEP[DUTY_W:0];
    localparam logic [DUTY_W:0] MAX_X  = {1'b0, DUTY_MAX};

    logic tick;

    pwm_tick_gen #(
        .TICK_W (TICK_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ------------------------------------------------------------------
    // Key path: the key value acted upon at a tick
    // ------------------------------------------------------------------
    logic [1:0] key_act;

`ifdef KEY_DEBOUNCE_EN
    logic [1:0] key_meta_q, key_meta_d;
    logic [1:0] key_sync_q, key_sync_d;
    logic [1:0] key_prev_q, key_prev_d;

    // The synchronised key only counts when it matches the value captured
    // at the previous tick, so a press first acts on its second tick.
    always_comb begin
        key_meta_d = key;
        key_sync_d = key_meta_q;
        key_prev_d = tick ? key_sync_q : key_prev_q;
        key_act    = (key_sync_q == key_prev_q) ? key_sync_q : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_q <= 2'b00;
            key_sync_q <= 2'b00;
            key_prev_q <= 2'b00;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            key_prev_q <= key_prev_d;
        end
    end
`else
    always_comb begin
        key_act = key;
    end
`endif

    // ------------------------------------------------------------------
    // Target, duty and ramp state
    // ------------------------------------------------------------------
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    pwm_state_e        state_q, state_d;
    logic              duty_upd_q, duty_upd_d;
    logic              host_acc;
    logic [DUTY_W:0]   tgt_up, tgt_dn, duty_up, duty_dn;

    assign busy      = (state_q != IDLE);
    assign set_ready = !busy;
    assign host_acc  = set_valid && set_ready;

    always_comb begin
        tgt_up  = {1'b0, target_q} + STEP_X;
        tgt_dn  = {1'b0, target_q} - STEP_X;
        duty_up = {1'b0, duty_q} + STEP_X;
        duty_dn = {1'b0, duty_q} - STEP_X;

        // Host command wins over a key tick in the same cycle.
        target_d = target_q;
        if (host_acc) begin
            target_d = (set_duty > DUTY_MAX) ? DUTY_MAX : set_duty;
        end else if (tick) begin
            if (key_act == KEY_INC) begin
                target_d = (tgt_up > MAX_X) ? DUTY_MAX : tgt_up[DUTY_W-1:0];
            end else if (key_act == KEY_DEC) begin
                target_d = ({1'b0, target_q} < STEP_X) ? '0 : tgt_dn[DUTY_W-1:0];
            end
        end

        // Steps are clamped to the current target so the ramp never
        // overshoots; the duty/target guard keeps a stale direction from
        // jumping when the target has just crossed the duty.
        duty_d = duty_q;
        if (tick) begin
            case (state_q)
                RAMP_UP: begin
                    if (duty_q < target_q) begin
                        duty_d = (duty_up > {1'b0, target_q}) ? target_q
                                                              : duty_up[DUTY_W-1:0];
                    end
                end
                RAMP_DN: begin
                    if (duty_q > target_q) begin
                        if (({1'b0, duty_q} < STEP_X) || (duty_dn < {1'b0, target_q})) begin
                            duty_d = target_q;
                        end else begin
                            duty_d = duty_dn[DUTY_W-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        // Direction is re-evaluated every cycle from the registered pair,
        // so busy follows duty/target one cycle later.
        state_d    = state_from(duty_q, target_q);
        duty_upd_d = (duty_d != duty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q     <= DUTY_INIT;
            target_q   <= DUTY_INIT;
            state_q    <= IDLE;
            duty_upd_q <= 1'b0;
        end else begin
            duty_q     <= duty_d;
            target_q   <= target_d;
            state_q    <= state_d;
            duty_upd_q <= duty_upd_d;
        end
    end

    assign duty     = duty_q;
    assign duty_upd = duty_upd_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl
//   Scoreboard bench for pwm_duty_ctrl (TICK_W=4, STEP=1, DUTY_INIT=0,
//   DUTY_MAX=1016). The stimulus process runs a behavioural model and
//   queues every expected duty change; a monitor pops one entry per
//   duty_upd pulse and also compares duty/busy/set_ready each cycle.
module tb_pwm_duty_ctrl;

    localparam int TW     = 4;
    localparam int STEPP  = 1;
    localparam int DINIT  = 0;
    localparam int DMAX   = 1016;
    localparam int PERIOD = 1 << TW;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key;
    logic       set_valid;
    logic [9:0] set_duty;
    logic       set_ready;
    logic [9:0] duty;
    logic       duty_upd;
    logic       busy;

    always #5 clk = ~clk;

    pwm_duty_ctrl #(
        .TICK_W    (TW),
        .STEP      (STEPP),
        .DUTY_INIT (10'd0),
        .DUTY_MAX  (10'd1016)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .set_valid (set_valid),
        .set_duty  (set_duty),
        .set_ready (set_ready),
        .duty      (duty),
        .duty_upd  (duty_upd),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_upd    = 0;
    int exp_q[$];

    // Model of the registered state visible in the current cycle.
    int m_duty, m_target, m_dir, m_cyc;
    bit mon_en = 1'b0;
`ifdef KEY_DEBOUNCE_EN
    int m_kd1, m_kd2, m_kprev;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict the effect of the coming edge from the driven inputs,
    // then advance one clock and return at the following negedge.
    task automatic step();
        int nd, nt, ndir, ak;
        bit tick, r;
        int k;
        r  = rst;
        k  = int'(key);
        nd = DINIT; nt = DINIT; ndir = 0;
`ifdef KEY_DEBOUNCE_EN
        int nkprev;
        nkprev = 0;
`endif
        if (!r) begin
            tick = (m_cyc > 0) && (m_cyc % PERIOD == 0);
            nt   = m_target;
            nd   = m_duty;
`ifdef KEY_DEBOUNCE_EN
            nkprev = tick ? m_kd2 : m_kprev;
            ak     = (m_kd2 == m_kprev) ? m_kd2 : 0;
`else
            ak = k;
`endif
            if (set_valid && m_dir == 0)
                nt = (int'(set_duty) > DMAX) ? DMAX : int'(set_duty);
            else if (tick && ak == 1)
                nt = (m_target + STEPP > DMAX) ? DMAX : m_target + STEPP;
            else if (tick && ak == 2)
                nt = (m_target < STEPP) ? 0 : m_target - STEPP;
            if (tick && m_dir > 0 && m_duty < m_target)
                nd = (m_duty + STEPP > m_target) ? m_target : m_duty + STEPP;
            if (tick && m_dir < 0 && m_duty > m_target)
                nd = (m_duty - STEPP < m_target) ? m_target : m_duty - STEPP;
            ndir = (m_duty < m_target) ? 1 : (m_duty > m_target) ? -1 : 0;
            if (nd != m_duty) exp_q.push_back(nd);
        end
        @(posedge clk);
        m_duty   = nd;
        m_target = nt;
        m_dir    = ndir;
        m_cyc    = r ? 0 : m_cyc + 1;
`ifdef KEY_DEBOUNCE_EN
        m_kprev = nkprev;
        m_kd2   = r ? 0 : m_kd1;
        m_kd1   = r ? 0 : k;
`endif
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; key = 2'b00; set_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("duty", int'(duty), m_duty);
            check("busy", int'(busy), (m_dir != 0) ? 1 : 0);
            check("set_ready", int'(set_ready), (m_dir == 0) ? 1 : 0);
            if (duty_upd) begin
                n_upd++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL duty_upd: pulse with duty=%0d, expected no pulse (t=%0t)", duty, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("upd_duty", int'(duty), e);
                end
            end
        end
    end

    initial begin
        int base;
        int guard;
        rst = 1'b1; key = 2'b00; set_valid = 1'b0; set_duty = '0;
        step();
        step();
        check("rst_duty", int'(duty), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(set_ready), 1);
        check("rst_upd", int'(duty_upd), 0);
        rst = 1'b0;

        // Host command 5 in IDLE: five single steps, one tick apart.
        base = n_upd;
        set_valid = 1'b1; set_duty = 10'd5;
        step();
        set_valid = 1'b0;
        run(5 * PERIOD + 8);
        check("host5_duty", int'(duty), 5);
        check("host5_pulses", n_upd - base, 5);
        check("host5_ready", int'(set_ready), 1);

        // Increase key held across three ticks from 0.
        do_reset();
        key = 2'b01;
        run(3 * PERIOD + 1);
        key = 2'b00;
        run(2 * PERIOD);
`ifdef KEY_DEBOUNCE_EN
        check("key_inc_duty", int'(duty), 2);
`else
        check("key_inc_duty", int'(duty), 3);
`endif

        // Decrease key at 0: nothing moves.
        do_reset();
        base = n_upd;
        key = 2'b10;
        run(3 * PERIOD + 1);
        key = 2'b00;
        run(4);
        check("dec_at0_duty", int'(duty), 0);
        check("dec_at0_pulses", n_upd - base, 0);

        // Host command lands on a key tick: host wins.
        do_reset();
        step();
        while (!((m_cyc > 0) && (m_cyc % PERIOD == 0))) step();
        key = 2'b01; set_valid = 1'b1; set_duty = 10'd8;
        step();
        key = 2'b00; set_valid = 1'b0;
        run(9 * PERIOD + 4);
        check("host_prio_duty", int'(duty), 8);

        // Decrease key during an upward ramp reverses it without overshoot.
        do_reset();
        set_valid = 1'b1; set_duty = 10'd5;
        step();
        set_valid = 1'b0;
        guard = 0;
        while (m_duty != 3 && guard < 200) begin step(); guard++; end
        check("rev_reach3", m_duty, 3);
        key = 2'b10;
        run(10 * PERIOD);
        key = 2'b00;
        run(2 * PERIOD);
        check("rev_duty", int'(duty), 0);

        // Reset mid-ramp at duty 4.
        do_reset();
        set_valid = 1'b1; set_duty = 10'd10;
        step();
        set_valid = 1'b0;
        guard = 0;
        while (m_duty != 4 && guard < 200) begin step(); guard++; end
        check("mid_reach4", m_duty, 4);
        rst = 1'b1;
        step();
        check("mid_rst_duty", int'(duty), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(set_ready), 1);
        check("mid_rst_upd", int'(duty_upd), 0);
        rst = 1'b0;

        // Randomised traffic with held keys and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) key = 2'($urandom_range(0, 3));
            set_valid = ($urandom_range(0, 7) == 0);
            set_duty  = 10'($urandom_range(0, 1023));
            rst       = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; set_valid = 1'b0; key = 2'b00;

        // Over-range host command clamps; duty stops at the maximum.
        do_reset();
        set_valid = 1'b1; set_duty = 10'd1023;
        step();
        set_valid = 1'b0;
        run((DMAX + 1) * PERIOD + 20);
        check("clamp_duty", int'(duty), DMAX);
        base = n_upd;
        key = 2'b01;
        run(3 * PERIOD + 1);
        key = 2'b00;
        run(4);
        check("inc_at_max_duty", int'(duty), DMAX);
        check("inc_at_max_pulses", n_upd - base, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ctrl.md
PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 SHALL have parameter TICK_W, default 16, ramp tick period of 2^TICK_W clk cycles.
REQ-002 SHALL have parameter STEP, default 1, duty increment per tick; legal range 1..64.
REQ-003 SHALL have parameter DUTY_INIT, default 10'd0, duty after reset.
REQ-004 SHALL have parameter DUTY_MAX, default 10'd1016, upper duty clamp.
REQ-005 SHALL have port clk  in  1  single system clock; all logic on posedge clk.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port key  in  2  operator request: 01 increase, 10 decrease, 00/11 none.
REQ-008 SHALL have port set_valid  in  1  host duty command valid.
REQ-009 SHALL have port set_duty  in  10  host target duty.
REQ-010 SHALL have port set_ready  out  1  host command acceptable.
REQ-011 SHALL have port duty  out  10  registered duty to the PWM generator.
REQ-012 SHALL have port duty_upd  out  1  one-cycle pulse in the cycle after duty changes.
REQ-013 SHALL have port busy  out  1  ramp in progress.

Function
REQ-014 SHALL generate tick as a one-cycle pulse when the TICK_W-bit free-running counter wraps from all-ones to zero.
REQ-015 SHALL accept a host command when set_valid and set_ready are both high, loading target = min(set_duty, DUTY_MAX) at the next edge.
REQ-016 SHALL drive set_ready = !busy, so host commands are refused during a ramp; set_valid while set_ready is low is ignored and no command is lost-tracked.
REQ-017 SHALL, on tick with no host command accepted that cycle, load target = min(target+STEP, DUTY_MAX) for key 01 and target = max(target-STEP, 0) for key 10, using 11-bit arithmetic.
REQ-018 SHALL give the host command priority when it is accepted in the same cycle as a key-driven tick; the key action for that tick is dropped.
REQ-019 SHALL implement FSM states IDLE (duty==target), RAMP_UP (duty<target), and RAMP_DN (duty>target), re-evaluated every cycle from duty versus target.
REQ-020 SHALL, on tick in RAMP_UP, set duty = min(duty+STEP, target), and in RAMP_DN set duty = max(duty-STEP, target), with no overshoot.
REQ-021 SHALL follow a target change mid-ramp in the cycle after the change, including reversing direction.
REQ-022 SHALL assert busy = (state != IDLE), and on duty reaching target SHALL return to IDLE and deassert busy one cycle later.
REQ-023 SHALL pulse duty_upd for exactly one cycle per duty change and never pulse it when duty is unchanged.
REQ-024 SHALL hold duty at 0 on a decrease request at 0, and at DUTY_MAX on an increase request at DUTY_MAX, with no duty_upd pulse.

Reset
REQ-025 SHALL set, while rst is high: duty=DUTY_INIT, target=DUTY_INIT, state=IDLE, tick counter=0, duty_upd=0, busy=0, set_ready=1.
REQ-026 SHALL abort a ramp in progress on reset mid-ramp, with no duty_upd pulse generated by the reset itself.

Configuration
REQ-027 SHALL, with KEY_DEBOUNCE_EN defined, pass key through a 2-flop synchronizer and act on a tick only when the synchronized key value equals the value sampled at the previous tick; key action therefore occurs on the second tick of a stable press.
REQ-028 SHALL, without KEY_DEBOUNCE_EN, sample key directly on each tick and act on the first tick.

Structure
REQ-029 SHALL place DUTY_W=10, the FSM state enumeration, and the key encoding constants (KEY_INC, KEY_DEC) in the shared package pwm_ctrl_pkg.
REQ-030 SHALL implement the tick counter and wrap pulse as sub-module pwm_tick_gen (parameter TICK_W, ports clk, rst, tick).

Verification (TICK_W=4, STEP=1, DUTY_INIT=0, DUTY_MAX=1016, macro off unless stated)
REQ-031 SHALL cover: host set_duty=5 accepted in IDLE -> busy rises, duty steps 1..5 on successive ticks (16 cycles apart), five duty_upd pulses, then busy=0 and set_ready=1.
REQ-032 SHALL cover: key=01 held for 3 ticks from duty 0 -> target and duty reach 3; with KEY_DEBOUNCE_EN -> reach 2.
REQ-033 SHALL cover: key=10 at duty 0, and set_duty=1023 -> duty stays 0 with no duty_upd; target clamps to 1016, and duty never exceeds 1016.
REQ-034 SHALL cover: host command accepted on the same cycle as a key=01 tick, set_duty=8 -> target=8 and the key action is dropped.
REQ-035 SHALL cover: key=10 held during a ramp to 5 at duty 3 -> target drops below duty, state goes to RAMP_DN next cycle, and duty decreases without overshoot.
REQ-036 SHALL cover: rst asserted at duty 4 mid-ramp -> next cycle duty=0, busy=0, set_ready=1, and no duty_upd pulse.
